// File: rtl/instruction_packet_issuer.sv
// instruction_packet_issuer
//   Queues host CORDIC requests in a small FIFO and issues them one at a time
//   as tagged 108-bit instruction packets to the x/y pre-process stage. It then
//   waits for that stage to report completion before issuing the next packet.
//
// Parameters
//   FIFO_DEPTH      request-queue entries (power of two, 2..16)
//   TIMEOUT_CYCLES  WAIT cycles before a packet is abandoned (1..65535)
//
// Ports
//   clock              single clock, rising edge
//   reset              synchronous, active-high
//   req_valid/ready    host request handshake
//   req_opcode         4-bit CORDIC opcode
//   req_x/y/z          32-bit operand words
//   InstructionPacket  {tag[7:0], opcode[3:0], z, y, x}, held until the next pop
//   PacketValid        one-cycle strobe marking a new InstructionPacket
//   InputReady         pre-process stage done (ignored during ISSUE)
//   busy               queue non-empty or packet in flight
//   timeout_err        sticky watchdog flag
//
// Build option
//   ISSUER_TIMEOUT_EN  enables the WAIT watchdog. When it is undefined, WAIT
//                      never times out and timeout_err is tied to 0.
module instruction_packet_issuer #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [3:0]   req_opcode,
   input  logic [31:0]  req_x,
   input  logic [31:0]  req_y,
   input  logic [31:0]  req_z,
   output logic [107:0] InstructionPacket,
   output logic         PacketValid,
   input  logic         InputReady,
   output logic         busy,
   output logic         timeout_err
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} stateType;

   stateType           state;
   logic [99:0]        fifoMem [FIFO_DEPTH];
   logic [PtrW-1:0]    wrPtr;
   logic [PtrW-1:0]    rdPtr;
   logic [PtrW:0]      count;
   logic [7:0]         tagCnt;
   logic               doPush;
   logic               doPop;

   // Readiness is judged on the registered count only, so a same-edge pop
   // never frees a slot for the request arriving on that edge.
   assign req_ready = (count < DepthCnt);
   assign doPush    = req_valid & req_ready;
   assign doPop     = (state == StIdle) && (count != '0);
   assign busy      = (state != StIdle) || (count != '0);

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clock) begin
      if (doPush && !reset) begin
         fifoMem[wrPtr] <= {req_opcode, req_z, req_y, req_x};
      end
   end

`ifdef ISSUER_TIMEOUT_EN
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wdCnt;
   logic        timeoutErr;
   assign timeout_err = timeoutErr;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= StIdle;
         wrPtr             <= '0;
         rdPtr             <= '0;
         count             <= '0;
         tagCnt            <= '0;
         InstructionPacket <= '0;
         PacketValid       <= 1'b0;
`ifdef ISSUER_TIMEOUT_EN
         wdCnt             <= '0;
         timeoutErr        <= 1'b0;
`endif
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;

         unique case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         case (state)
            StIdle: begin
               PacketValid <= 1'b0;
               if (doPop) begin
                  InstructionPacket <= {tagCnt, fifoMem[rdPtr]};
                  tagCnt            <= tagCnt + 1'b1;
                  PacketValid       <= 1'b1;
                  state             <= StIssue;
               end
            end
            StIssue: begin
               PacketValid <= 1'b0;
               state       <= StWait;
`ifdef ISSUER_TIMEOUT_EN
               wdCnt       <= '0;
`endif
            end
            StWait: begin
               PacketValid <= 1'b0;
               // Completion wins over a watchdog expiry on the same edge.
               if (InputReady) begin
                  state <= StIdle;
               end
`ifdef ISSUER_TIMEOUT_EN
               else if (wdCnt == TimeoutLast) begin
                  state      <= StIdle;
                  timeoutErr <= 1'b1;
               end else begin
                  wdCnt <= wdCnt + 1'b1;
               end
`endif
            end
            default: begin
               PacketValid <= 1'b0;
               state       <= StIdle;
            end
         endcase
      end
   end

endmodule
